// File: rtl/vpu_lane_issue_ctrl_pkg.sv
// vpu_lane_issue_ctrl_pkg: shared VPU lane request, error and controller state types
package vpu_lane_issue_ctrl_pkg;
  localparam int OPERAND_WIDTH = 16;
  localparam int SRC_OPERAND_CNT = 3;
  localparam int LANE_TIMEOUT_DEFAULT = 64;
  typedef struct packed {
    logic fp_div;
    logic fp_fma;
    logic fp_mul;
    logic fp_add;
  } vpu_fp_req_t;
  typedef struct packed {
    vpu_fp_req_t fp_req;
  } vpu_exec_req_t;
  typedef enum logic [1:0] {
    ERR_OK = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_ILLEGAL_OP = 2'b10
  } lane_ctrl_err_t;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lane_ctrl_state_t;
endpackage

// File: rtl/vpu_lane_watchdog.sv
// vpu_lane_watchdog: clear/enable counter that saturates at LIMIT-1 and flags expiry
module vpu_lane_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(LIMIT - 1);
  // count up while enabled, parking at the expiry value so it never wraps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/vpu_lane_issue_ctrl.sv
// vpu_lane_issue_ctrl: single-outstanding issue/collect controller in front of the VPU lane
module vpu_lane_issue_ctrl
  import vpu_lane_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LANE_TIMEOUT_DEFAULT,
  parameter int DST_WIDTH = 5
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            req_valid_i,
  output logic                                            req_ready_o,
  input  vpu_exec_req_t                                   req_op_func_i,
  input  logic [SRC_OPERAND_CNT-1:0][OPERAND_WIDTH-1:0]   req_operand_i,
  input  logic [SRC_OPERAND_CNT-1:0]                      req_operand_valid_i,
  input  logic [DST_WIDTH-1:0]                            req_dst_i,
  output logic                                            lane_start_o,
  output vpu_exec_req_t                                   lane_op_func_o,
  output logic [SRC_OPERAND_CNT-1:0][OPERAND_WIDTH-1:0]   lane_operand_o,
  output logic [SRC_OPERAND_CNT-1:0]                      lane_operand_valid_o,
  input  logic [OPERAND_WIDTH-1:0]                        lane_dout_i,
  input  logic                                            lane_done_i,
  output logic                                            rsp_valid_o,
  input  logic                                            rsp_ready_i,
  output logic [OPERAND_WIDTH-1:0]                        rsp_data_o,
  output logic [DST_WIDTH-1:0]                            rsp_dst_o,
  output lane_ctrl_err_t                                  rsp_err_o
);
  lane_ctrl_state_t state, state_n;
  logic expired, accept, illegal, capture, tmo, issue_ok;
  vpu_lane_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk(clk),
    .rst_n(rst_n),
    .clr(state == ISSUE),
    .en(state == WAIT),
    .expired(expired)
  );
  assign req_ready_o = state == IDLE;
  assign accept = req_ready_o && req_valid_i;
  assign illegal = req_op_func_i.fp_req == '0;
  assign issue_ok = accept && !illegal;
  assign capture = (state == ISSUE || state == WAIT) && lane_done_i;
  assign tmo = state == WAIT && !lane_done_i && expired;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state; done has priority over the watchdog
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = accept ? (illegal ? RESP : ISSUE) : IDLE;
      ISSUE: state_n = lane_done_i ? RESP : WAIT;
      WAIT:  state_n = (lane_done_i || expired) ? RESP : WAIT;
      RESP:  state_n = rsp_ready_i ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // lane hold registers: loaded on a legal accept, cleared once the lane is finished with
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      lane_start_o <= 1'b0;
      lane_op_func_o <= '0;
      lane_operand_o <= '0;
      lane_operand_valid_o <= '0;
    end else begin
      lane_start_o <= issue_ok;
      if (issue_ok) begin
        lane_op_func_o <= req_op_func_i;
        lane_operand_o <= req_operand_i;
        lane_operand_valid_o <= req_operand_valid_i;
      end else if (capture || tmo) begin
        lane_op_func_o <= '0;
        lane_operand_o <= '0;
        lane_operand_valid_o <= '0;
      end
    end
  // response register: filled on completion, held until writeback takes it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o <= '0;
      rsp_dst_o <= '0;
      rsp_err_o <= ERR_OK;
    end else begin
      if (accept) rsp_dst_o <= req_dst_i;
      if (accept && illegal) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o <= '0;
        rsp_err_o <= ERR_ILLEGAL_OP;
      end else if (capture) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o <= lane_dout_i;
        rsp_err_o <= ERR_OK;
      end else if (tmo) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o <= '0;
        rsp_err_o <= ERR_TIMEOUT;
      end else if (state == RESP && rsp_ready_i) rsp_valid_o <= 1'b0;
    end
endmodule

// File: tb/tb_vpu_lane_issue_ctrl.sv
// tb_vpu_lane_issue_ctrl: directed checks of issue, timeout, illegal-op, back-pressure and reset
module tb_vpu_lane_issue_ctrl;
  import vpu_lane_issue_ctrl_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  logic req_valid = 0, rsp_ready = 0, lane_done = 0;
  vpu_exec_req_t req_op = '0;
  logic [SRC_OPERAND_CNT-1:0][OPERAND_WIDTH-1:0] req_operand = '0;
  logic [SRC_OPERAND_CNT-1:0] req_operand_valid = '0;
  logic [4:0] req_dst = '0;
  logic [OPERAND_WIDTH-1:0] lane_dout = '0;
  logic req_ready, lane_start, rsp_valid;
  vpu_exec_req_t lane_op;
  logic [SRC_OPERAND_CNT-1:0][OPERAND_WIDTH-1:0] lane_operand;
  logic [SRC_OPERAND_CNT-1:0] lane_operand_valid;
  logic [OPERAND_WIDTH-1:0] rsp_data;
  logic [4:0] rsp_dst;
  logic [1:0] rsp_err;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  vpu_lane_issue_ctrl #(.TIMEOUT_CYCLES(8), .DST_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_func_i(req_op),
    .req_operand_i(req_operand), .req_operand_valid_i(req_operand_valid), .req_dst_i(req_dst),
    .lane_start_o(lane_start), .lane_op_func_o(lane_op), .lane_operand_o(lane_operand),
    .lane_operand_valid_o(lane_operand_valid), .lane_dout_i(lane_dout), .lane_done_i(lane_done),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_dst_o(rsp_dst), .rsp_err_o(rsp_err)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    tick; tick;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", req_ready); end
    tests++; if (lane_start !== 1'b0) begin fails++; $display("FAIL reset_start got %b want 0", lane_start); end
    tests++; if (lane_op !== 4'b0 || lane_operand !== '0 || lane_operand_valid !== 3'b0) begin fails++; $display("FAIL reset_lane got %h/%h/%b want 0", lane_op, lane_operand, lane_operand_valid); end
    tests++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_dst !== 5'd0 || rsp_err !== 2'b00) begin fails++; $display("FAIL reset_rsp got %b/%h/%0d/%b want 0/0/0/00", rsp_valid, rsp_data, rsp_dst, rsp_err); end
    rst_n = 1;
    tick;
    tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("FAIL post_reset got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
  endtask

  task automatic test_fp_mul;
    req_valid = 1; req_op = 4'b0010; req_operand = {16'h0003, 16'h0002, 16'h0001}; req_operand_valid = 3'b011; req_dst = 5'd3;
    tick; req_valid = 0;
    tests++; if (lane_start !== 1'b1 || req_ready !== 1'b0) begin fails++; $display("FAIL mul_start got start=%b ready=%b want 1/0", lane_start, req_ready); end
    tests++; if (lane_op !== 4'b0010 || lane_operand !== {16'h0003, 16'h0002, 16'h0001} || lane_operand_valid !== 3'b011) begin fails++; $display("FAIL mul_lane_regs got %h/%h/%b want 2/000300020001/011", lane_op, lane_operand, lane_operand_valid); end
    for (int i = 2; i <= 4; i++) begin
      tick;
      tests++; if (lane_start !== 1'b0 || rsp_valid !== 1'b0 || lane_op !== 4'b0010) begin fails++; $display("FAIL mul_wait%0d got start=%b valid=%b op=%h want 0/0/2", i, lane_start, rsp_valid, lane_op); end
      if (i == 4) begin lane_done = 1; lane_dout = 16'h3F80; end
    end
    tick; lane_done = 0;
    tests++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h3F80 || rsp_dst !== 5'd3 || rsp_err !== 2'b00) begin fails++; $display("FAIL mul_rsp got %b/%h/%0d/%b want 1/3f80/3/00", rsp_valid, rsp_data, rsp_dst, rsp_err); end
    tests++; if (lane_op !== 4'b0 || lane_operand !== '0) begin fails++; $display("FAIL mul_lane_clear got %h/%h want 0", lane_op, lane_operand); end
    rsp_ready = 1; tick; rsp_ready = 0;
    tests++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL mul_handshake got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_illegal;
    req_valid = 1; req_op = 4'b0000; req_dst = 5'd7;
    tick; req_valid = 0;
    tests++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0 || rsp_dst !== 5'd7 || rsp_err !== 2'b10) begin fails++; $display("FAIL illegal_rsp got %b/%h/%0d/%b want 1/0/7/10", rsp_valid, rsp_data, rsp_dst, rsp_err); end
    tests++; if (lane_start !== 1'b0 || lane_op !== 4'b0) begin fails++; $display("FAIL illegal_nostart got start=%b op=%h want 0/0", lane_start, lane_op); end
    rsp_ready = 1; tick; rsp_ready = 0;
    tests++; if (rsp_valid !== 1'b0 || lane_start !== 1'b0) begin fails++; $display("FAIL illegal_done got valid=%b start=%b want 0/0", rsp_valid, lane_start); end
  endtask

  task automatic test_timeout;
    req_valid = 1; req_op = 4'b0100; req_dst = 5'd11;
    tick; req_valid = 0;
    for (int i = 1; i <= 9; i++) begin
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL tmo_early at T+%0d got valid=%b want 0", i, rsp_valid); end
      tick;
    end
    tests++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0 || rsp_dst !== 5'd11 || rsp_err !== 2'b01) begin fails++; $display("FAIL tmo_rsp got %b/%h/%0d/%b want 1/0/11/01", rsp_valid, rsp_data, rsp_dst, rsp_err); end
    lane_done = 1; lane_dout = 16'hBEEF;
    tick; lane_done = 0;
    tests++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h0 || rsp_err !== 2'b01) begin fails++; $display("FAIL tmo_late_done got %b/%h/%b want 1/0/01", rsp_valid, rsp_data, rsp_err); end
    rsp_ready = 1; tick; rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (rsp_valid !== 1'b0 || lane_start !== 1'b0) begin fails++; $display("FAIL tmo_no_second got valid=%b start=%b want 0/0", rsp_valid, lane_start); end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    req_valid = 1; req_op = 4'b0100; req_dst = 5'd12;
    tick;
    tests++; if (lane_start !== 1'b1) begin fails++; $display("FAIL bp_start got %b want 1", lane_start); end
    tick; lane_done = 1; lane_dout = 16'h1234;
    tick; lane_done = 0;
    for (int i = 0; i < 5; i++) begin
      tests++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h1234 || rsp_dst !== 5'd12 || rsp_err !== 2'b00 || req_ready !== 1'b0) begin fails++; $display("FAIL bp_hold%0d got %b/%h/%0d/%b ready=%b want 1/1234/12/00 ready=0", i, rsp_valid, rsp_data, rsp_dst, rsp_err, req_ready); end
      tick;
    end
    rsp_ready = 1; req_op = 4'b0001; req_dst = 5'd20; req_operand = {16'hC, 16'hB, 16'hA}; req_operand_valid = 3'b111;
    tick; rsp_ready = 0;
    tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || lane_start !== 1'b0) begin fails++; $display("FAIL b2b_idle got ready=%b valid=%b start=%b want 1/0/0", req_ready, rsp_valid, lane_start); end
    tick; req_valid = 0;
    tests++; if (lane_start !== 1'b1 || lane_op !== 4'b0001 || lane_operand_valid !== 3'b111) begin fails++; $display("FAIL b2b_start got start=%b op=%h ov=%b want 1/1/111", lane_start, lane_op, lane_operand_valid); end
    tick; lane_done = 1; lane_dout = 16'h5678;
    tick; lane_done = 0;
    tests++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h5678 || rsp_dst !== 5'd20) begin fails++; $display("FAIL b2b_rsp got %b/%h/%0d want 1/5678/20", rsp_valid, rsp_data, rsp_dst); end
    rsp_ready = 1; tick; rsp_ready = 0;
  endtask

  task automatic test_done_at_start;
    req_valid = 1; req_op = 4'b0001; req_dst = 5'd9;
    tick; req_valid = 0;
    tests++; if (lane_start !== 1'b1) begin fails++; $display("FAIL das_start got %b want 1", lane_start); end
    lane_done = 1; lane_dout = 16'hA5A5;
    tick; lane_done = 0;
    tests++; if (rsp_valid !== 1'b1 || rsp_data !== 16'hA5A5 || rsp_dst !== 5'd9 || rsp_err !== 2'b00) begin fails++; $display("FAIL das_rsp got %b/%h/%0d/%b want 1/a5a5/9/00", rsp_valid, rsp_data, rsp_dst, rsp_err); end
    rsp_ready = 1; tick; rsp_ready = 0;
  endtask

  task automatic test_reset_mid;
    req_valid = 1; req_op = 4'b0100; req_operand = {16'h7, 16'h6, 16'h5}; req_dst = 5'd5;
    tick; req_valid = 0;
    tick; tick;
    tests++; if (lane_op !== 4'b0100) begin fails++; $display("FAIL rm_wait_op got %h want 4", lane_op); end
    #2 rst_n = 0;
    #1;
    tests++; if (lane_op !== 4'b0 || lane_operand !== '0 || lane_operand_valid !== 3'b0 || lane_start !== 1'b0) begin fails++; $display("FAIL rm_lane got %h/%h/%b/%b want 0", lane_op, lane_operand, lane_operand_valid, lane_start); end
    tests++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_dst !== 5'd0 || rsp_err !== 2'b00 || rsp_data !== 16'h0) begin fails++; $display("FAIL rm_rsp got ready=%b %b/%h/%0d/%b want 1 0/0/0/00", req_ready, rsp_valid, rsp_data, rsp_dst, rsp_err); end
    tick; rst_n = 1;
    tick;
    req_valid = 1; req_op = 4'b1000; req_dst = 5'd17;
    tick; req_valid = 0;
    tests++; if (lane_start !== 1'b1 || lane_op !== 4'b1000) begin fails++; $display("FAIL rm_restart got start=%b op=%h want 1/8", lane_start, lane_op); end
    tick; lane_done = 1; lane_dout = 16'h7777;
    tick; lane_done = 0;
    tests++; if (rsp_valid !== 1'b1 || rsp_data !== 16'h7777 || rsp_dst !== 5'd17 || rsp_err !== 2'b00) begin fails++; $display("FAIL rm_rsp_after got %b/%h/%0d/%b want 1/7777/17/00", rsp_valid, rsp_data, rsp_dst, rsp_err); end
    rsp_ready = 1; tick; rsp_ready = 0;
  endtask

  initial begin
    test_reset;
    test_fp_mul;
    test_illegal;
    test_timeout;
    test_back_to_back;
    test_done_at_start;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
